// File: rtl/gpr_mp_pkg.sv
// gpr_mp_pkg: shared constants and types for the multi-port register file.
//   GPR_DATA_WIDTH / GPR_REG_NUM : default register width and register count
//   gpr_id_t / gpr_data_t        : index and data types at the default sizes
package gpr_mp_pkg;
  localparam int GPR_DATA_WIDTH = 32;
  localparam int GPR_REG_NUM    = 32;

  typedef logic [$clog2(GPR_REG_NUM)-1:0] gpr_id_t;
  typedef logic [GPR_DATA_WIDTH-1:0]      gpr_data_t;
endpackage

// File: rtl/gpr_mp_if.sv
// gpr_mp_if: bus between issue/writeback logic and the register file.
//   read    : i_rd_id (in), o_rd_data / o_rd_busy (out), packed per port
//   write   : i_wr_en / i_wr_id / i_wr_data, packed per port
//   pending : i_rsv_en / i_rsv_id (reserve), i_flush, o_busy_cnt
// Port k of a packed field occupies bits [k*W +: W].
// modport slave  : register file side
// modport master : pipeline side
interface gpr_mp_if
  import gpr_mp_pkg::*;
#(
  parameter int DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int REG_NUM    = GPR_REG_NUM,
  parameter int RD_PORTS   = 3,
  parameter int WR_PORTS   = 2,
  localparam int ID_WIDTH  = $clog2(REG_NUM)
);
  logic [RD_PORTS*ID_WIDTH-1:0]   i_rd_id;
  logic [RD_PORTS*DATA_WIDTH-1:0] o_rd_data;
  logic [RD_PORTS-1:0]            o_rd_busy;
  logic [WR_PORTS-1:0]            i_wr_en;
  logic [WR_PORTS*ID_WIDTH-1:0]   i_wr_id;
  logic [WR_PORTS*DATA_WIDTH-1:0] i_wr_data;
  logic                           i_rsv_en;
  logic [ID_WIDTH-1:0]            i_rsv_id;
  logic                           i_flush;
  logic [ID_WIDTH:0]              o_busy_cnt;

  modport slave (
    input  i_rd_id, i_wr_en, i_wr_id, i_wr_data, i_rsv_en, i_rsv_id, i_flush,
    output o_rd_data, o_rd_busy, o_busy_cnt
  );

  modport master (
    output i_rd_id, i_wr_en, i_wr_id, i_wr_data, i_rsv_en, i_rsv_id, i_flush,
    input  o_rd_data, o_rd_busy, o_busy_cnt
  );
endinterface

// File: rtl/gpr_mp_sb.sv
// gpr_mp_sb: pending-bit scoreboard for the register file.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   rd_id/rd_busy  : per-read-port pending lookup
//   wr_en/wr_id    : writebacks, clear pending of their target
//   rsv_en/rsv_id  : reservation, sets pending (wins over a same-id clear)
//   flush          : clears every pending bit (wins over everything)
//   busy_cnt       : registered popcount of the pending vector
// Macro GPR_MP_BYPASS_EN: busy lookup also sees same-cycle writes/reserves.
module gpr_mp_sb #(
  parameter int REG_NUM    = 32,
  parameter int RD_PORTS   = 3,
  parameter int WR_PORTS   = 2,
  localparam int ID_WIDTH  = $clog2(REG_NUM)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [RD_PORTS*ID_WIDTH-1:0] rd_id,
  output logic [RD_PORTS-1:0]          rd_busy,
  input  logic [WR_PORTS-1:0]          wr_en,
  input  logic [WR_PORTS*ID_WIDTH-1:0] wr_id,
  input  logic                         rsv_en,
  input  logic [ID_WIDTH-1:0]          rsv_id,
  input  logic                         flush,
  output logic [ID_WIDTH:0]            busy_cnt
);
  typedef logic [ID_WIDTH:0] cnt_t;

  logic [REG_NUM-1:0] pend, pend_nxt, clr, set;
  cnt_t               cnt_nxt;

  always_comb begin
    clr = '0;
    set = '0;
    for (int p = 0; p < WR_PORTS; p++)
      if (wr_en[p]) clr[wr_id[p*ID_WIDTH +: ID_WIDTH]] = 1'b1;
    if (rsv_en) set[rsv_id] = 1'b1;
    pend_nxt    = flush ? '0 : ((pend & ~clr) | set);
    pend_nxt[0] = 1'b0;
    // Incremental update: one step per bit that actually flips, so a
    // double clear of one id counts once and the count cannot wrap.
    cnt_nxt = busy_cnt;
    for (int r = 0; r < REG_NUM; r++) begin
      if (pend_nxt[r] && !pend[r]) cnt_nxt = cnt_nxt + cnt_t'(1);
      if (!pend_nxt[r] && pend[r]) cnt_nxt = cnt_nxt - cnt_t'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pend     <= '0;
      busy_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      logic [ID_WIDTH-1:0] rid;
      logic                b;
      rid = rd_id[k*ID_WIDTH +: ID_WIDTH];
      b   = pend[rid];
`ifdef GPR_MP_BYPASS_EN
      // An in-flight writeback to this id resolves the hazard, unless a
      // new producer is reserving it in the same cycle.
      for (int p = 0; p < WR_PORTS; p++)
        if (wr_en[p] && wr_id[p*ID_WIDTH +: ID_WIDTH] == rid)
          b = rsv_en && (rsv_id == rid);
`endif
      rd_busy[k] = i_rst_n && (rid != '0) && b;
    end
  end
endmodule

// File: rtl/gpr_mp.sv
// gpr_mp: parametrised multi-port general-purpose register file.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   bus (slave)    : RD_PORTS combinational reads with pending bit,
//                    WR_PORTS writes (highest port wins on same id),
//                    reserve / flush of pending bits, busy count
// Register 0 reads 0 and is never pending.
// Macro GPR_MP_BYPASS_EN: reads forward same-cycle write data.
module gpr_mp
  import gpr_mp_pkg::*;
#(
  parameter int DATA_WIDTH = GPR_DATA_WIDTH,
  parameter int REG_NUM    = GPR_REG_NUM,
  parameter int RD_PORTS   = 3,
  parameter int WR_PORTS   = 2,
  localparam int ID_WIDTH  = $clog2(REG_NUM)
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  gpr_mp_if.slave   bus
);
  logic [REG_NUM-1:0][DATA_WIDTH-1:0]  regs;
  logic [RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  // Later non-blocking assignments win, so ascending port order gives the
  // highest-numbered port priority on a shared index.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      regs <= '0;
    end else begin
      for (int p = 0; p < WR_PORTS; p++)
        if (bus.i_wr_en[p] && bus.i_wr_id[p*ID_WIDTH +: ID_WIDTH] != '0)
          regs[bus.i_wr_id[p*ID_WIDTH +: ID_WIDTH]] <=
            bus.i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      logic [ID_WIDTH-1:0] rid;
      rid        = bus.i_rd_id[k*ID_WIDTH +: ID_WIDTH];
      rd_data[k] = regs[rid];
`ifdef GPR_MP_BYPASS_EN
      for (int p = 0; p < WR_PORTS; p++)
        if (bus.i_wr_en[p] && bus.i_wr_id[p*ID_WIDTH +: ID_WIDTH] == rid)
          rd_data[k] = bus.i_wr_data[p*DATA_WIDTH +: DATA_WIDTH];
`endif
      // Array contents are undefined until the first reset edge; mask them.
      if (!i_rst_n || rid == '0) rd_data[k] = '0;
    end
  end

  assign bus.o_rd_data = rd_data;

  gpr_mp_sb #(
    .REG_NUM  (REG_NUM),
    .RD_PORTS (RD_PORTS),
    .WR_PORTS (WR_PORTS)
  ) u_sb (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .rd_id    (bus.i_rd_id),
    .rd_busy  (bus.o_rd_busy),
    .wr_en    (bus.i_wr_en),
    .wr_id    (bus.i_wr_id),
    .rsv_en   (bus.i_rsv_en),
    .rsv_id   (bus.i_rsv_id),
    .flush    (bus.i_flush),
    .busy_cnt (bus.o_busy_cnt)
  );
endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: directed self-checking bench for gpr_mp (default parameters).
// Honours GPR_MP_BYPASS_EN for the same-cycle read expectation.
module tb_gpr_mp;
  import gpr_mp_pkg::*;

  localparam int DW = 32;
  localparam int IW = 5;

  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 i_clk = ~i_clk;

  gpr_mp_if #(.DATA_WIDTH(32), .REG_NUM(32), .RD_PORTS(3), .WR_PORTS(2)) bus ();

  gpr_mp #(.DATA_WIDTH(32), .REG_NUM(32), .RD_PORTS(3), .WR_PORTS(2)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic gpr_data_t rd(input int k);
    return bus.o_rd_data[k*DW +: DW];
  endfunction

  task automatic setrd(input int k, input gpr_id_t id);
    bus.i_rd_id[k*IW +: IW] = id;
  endtask

  task automatic wr(input int p, input gpr_id_t id, input gpr_data_t d);
    bus.i_wr_en[p]           = 1'b1;
    bus.i_wr_id[p*IW +: IW]  = id;
    bus.i_wr_data[p*DW +: DW] = d;
  endtask

  task automatic rsv(input gpr_id_t id);
    bus.i_rsv_en = 1'b1;
    bus.i_rsv_id = id;
  endtask

  task automatic idle();
    bus.i_wr_en  = '0;
    bus.i_rsv_en = 1'b0;
    bus.i_flush  = 1'b0;
  endtask

  // One edge, then drop the strobes so checks see stored state only.
  task automatic tick();
    @(posedge i_clk);
    #1;
    idle();
    #1;
  endtask

  initial begin
    i_rst_n       = 1'b0;
    bus.i_rd_id   = '0;
    bus.i_wr_id   = '0;
    bus.i_wr_data = '0;
    bus.i_rsv_id  = '0;
    idle();
    tick();
    i_rst_n = 1'b1;

    // 1: preload, then reset clears data, pending and count
    wr(0, 5'd3, 32'h0000_0011);
    wr(1, 5'd4, 32'h0000_0022);
    tick();
    rsv(5'd3);
    tick();
    setrd(0, 5'd3); setrd(1, 5'd4); #1;
    chk("preload_x3", rd(0), 32'h0000_0011);
    chk("preload_x4", rd(1), 32'h0000_0022);
    chk("preload_cnt", 32'(bus.o_busy_cnt), 32'd1);
    i_rst_n = 1'b0;
    tick();
    chk("rst_x3", rd(0), 32'h0);
    chk("rst_x4", rd(1), 32'h0);
    chk("rst_busy", 32'(bus.o_rd_busy), 32'h0);
    chk("rst_cnt", 32'(bus.o_busy_cnt), 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("post_rst_x3", rd(0), 32'h0);

    // 2: same-id double write, highest port wins; x0 write discarded
    wr(0, 5'd5, 32'hDEAD_BEEF);
    wr(1, 5'd5, 32'h1234_5678);
    tick();
    setrd(0, 5'd5); #1;
    chk("wr_prio_x5", rd(0), 32'h1234_5678);
    wr(0, 5'd0, 32'hFFFF_FFFF);
    tick();
    setrd(1, 5'd0); #1;
    chk("x0_zero", rd(1), 32'h0);
    chk("x0_busy", 32'(bus.o_rd_busy[1]), 32'd0);

    // 3: reserve, reserve+write same id keeps pending, plain write clears
    rsv(5'd7);
    tick();
    setrd(0, 5'd7); #1;
    chk("rsv_busy", 32'(bus.o_rd_busy[0]), 32'd1);
    chk("rsv_cnt", 32'(bus.o_busy_cnt), 32'd1);
    wr(0, 5'd7, 32'hA5A5_A5A5);
    rsv(5'd7);
    tick();
    chk("rsvwr_busy", 32'(bus.o_rd_busy[0]), 32'd1);
    chk("rsvwr_cnt", 32'(bus.o_busy_cnt), 32'd1);
    chk("rsvwr_data", rd(0), 32'hA5A5_A5A5);
    wr(0, 5'd7, 32'hA5A5_A5A5);
    tick();
    chk("clr_busy", 32'(bus.o_rd_busy[0]), 32'd0);
    chk("clr_cnt", 32'(bus.o_busy_cnt), 32'd0);
    // double clear of one pending id decrements once
    rsv(5'd8);
    tick();
    wr(0, 5'd8, 32'h1);
    wr(1, 5'd8, 32'h2);
    tick();
    setrd(2, 5'd8); #1;
    chk("dblclr_cnt", 32'(bus.o_busy_cnt), 32'd0);
    chk("dblclr_data", rd(2), 32'h2);

    // 4: reserves accumulate, re-reserve does not nest, flush beats reserve
    rsv(5'd1); tick();
    rsv(5'd2); tick();
    rsv(5'd3); tick();
    rsv(5'd3); tick();
    chk("rsv3_cnt", 32'(bus.o_busy_cnt), 32'd3);
    bus.i_flush = 1'b1;
    rsv(5'd4);
    wr(0, 5'd1, 32'h0000_0077);
    tick();
    setrd(0, 5'd1); setrd(1, 5'd2); setrd(2, 5'd4); #1;
    chk("flush_busy", 32'(bus.o_rd_busy), 32'h0);
    chk("flush_cnt", 32'(bus.o_busy_cnt), 32'd0);
    chk("flush_wdata", rd(0), 32'h0000_0077);
    setrd(0, 5'd3); #1;
    chk("flush_x3", 32'(bus.o_rd_busy[0]), 32'd0);

    // 5: same-cycle read of a write
    setrd(2, 5'd9);
    wr(0, 5'd9, 32'h0000_00FF);
    #1;
`ifdef GPR_MP_BYPASS_EN
    chk("same_cycle_x9", rd(2), 32'h0000_00FF);
`else
    chk("same_cycle_x9", rd(2), 32'h0);
`endif
    chk("same_cycle_busy", 32'(bus.o_rd_busy[2]), 32'd0);
    tick();
    chk("next_cycle_x9", rd(2), 32'h0000_00FF);

    // 6: reset wins over reserve and write in the same cycle
    rsv(5'd10);
    wr(0, 5'd11, 32'h0000_0055);
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    setrd(0, 5'd11); setrd(1, 5'd10); setrd(2, 5'd9); #1;
    chk("rst_mid_x11", rd(0), 32'h0);
    chk("rst_mid_busy", 32'(bus.o_rd_busy[1]), 32'd0);
    chk("rst_mid_cnt", 32'(bus.o_busy_cnt), 32'd0);
    chk("rst_mid_x9", rd(2), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
